alu_resp_checker: RTL and testbench

ALU_RESP_CHECKER -- requirements
Module: alu_resp_checker

---
 rtl/alu_chk_pkg.sv | 6 +
 rtl/alu_resp_checker_if.sv | 15 +
 rtl/alu_resp_cmp.sv | 17 +
 rtl/alu_resp_checker.sv | 84 ++++++++
 tb/tb_alu_resp_checker.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg: shared FSM state type and default widths for the ALU response checker.
package alu_chk_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W  = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/alu_resp_checker_if.sv
// alu_resp_checker_if: DUT-result and expected-value streams feeding the checker.
interface alu_resp_checker_if #(parameter int DATA_W = 64);
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              exp_valid;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_result;
    logic              exp_zero;
    modport master (output res_valid, result, zero, exp_valid, exp_result, exp_zero,
                    input  res_ready, exp_ready);
    modport slave  (input  res_valid, result, zero, exp_valid, exp_result, exp_zero,
                    output res_ready, exp_ready);
endinterface

// File: rtl/alu_resp_cmp.sv
// alu_resp_cmp: pair compare; ZERO_CHECK_EN also compares the zero flags.
module alu_resp_cmp #(parameter int DATA_W = alu_chk_pkg::DEF_DATA_W) (
    input  logic [DATA_W-1:0] result,
    input  logic              zero,
    input  logic [DATA_W-1:0] exp_result,
    input  logic              exp_zero,
    output logic              mismatch
);
    // Case inequality so unknown bits in simulation are reported as mismatches.
`ifdef ZERO_CHECK_EN
    assign mismatch = (result !== exp_result) || (zero !== exp_zero);
`else
    logic unused_zero;
    assign unused_zero = zero ^ exp_zero;
    assign mismatch    = result !== exp_result;
`endif
endmodule

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: consumes result/expected pairs, counts vectors and mismatches (ZERO_CHECK_EN adds zero-flag compare).
module alu_resp_checker
    import alu_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    alu_resp_checker_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, vec_q, vec_d, err_q, err_d, idx_q, idx_d;
    logic             fev_q, fev_d, fire, mismatch;

    assign fire          = (state_q == RUN) && bus.res_valid && bus.exp_valid;
    assign bus.res_ready = fire;
    assign bus.exp_ready = fire;

    alu_resp_cmp #(.DATA_W(DATA_W)) u_cmp (
        .result    (bus.result),
        .zero      (bus.zero),
        .exp_result(bus.exp_result),
        .exp_zero  (bus.exp_zero),
        .mismatch  (mismatch)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        vec_d   = vec_q;
        err_d   = err_q;
        idx_d   = idx_q;
        fev_d   = fev_q;
        if (state_q != RUN && start) begin
            num_d   = num_vectors;
            vec_d   = '0;
            err_d   = '0;
            fev_d   = 1'b0;
            state_d = (num_vectors == '0) ? DONE : RUN;
        end else if (fire) begin
            vec_d = vec_q + 1'b1;
            if (mismatch) begin
                err_d = &err_q ? err_q : err_q + 1'b1;
                idx_d = fev_q ? idx_q : vec_q;
                fev_d = 1'b1;
            end
            if (vec_d == num_q) state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            fev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            fev_q   <= fev_d;
        end
    end

    assign busy            = state_q == RUN;
    assign done            = state_q == DONE;
    assign vec_count       = vec_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = idx_q;
endmodule

// File: tb/tb_alu_resp_checker.sv
// tb_alu_resp_checker: directed table-driven bench for alu_resp_checker.
module tb_alu_resp_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vectors = '0;
    logic        busy, done, first_err_valid;
    logic [15:0] vec_count, err_count, first_err_idx;
    int          total = 0;
    int          bad = 0;

    alu_resp_checker_if #(.DATA_W(64)) bus ();

    alu_resp_checker dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_vectors    (num_vectors),
        .bus            (bus.slave),
        .busy           (busy),
        .done           (done),
        .vec_count      (vec_count),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_idx  (first_err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r;
        logic [63:0] e;
        logic        z;
        logic        ez;
        logic [15:0] v;
        logic [15:0] er;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic start_run(input logic [15:0] n);
        @(negedge clk);
        start       = 1'b1;
        num_vectors = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_pair(input logic [63:0] r, input logic [63:0] e, input logic z, input logic ez);
        @(negedge clk);
        bus.res_valid  = 1'b1;
        bus.exp_valid  = 1'b1;
        bus.result     = r;
        bus.exp_result = e;
        bus.zero       = z;
        bus.exp_zero   = ez;
        #1 chk("ready", {62'd0, bus.res_ready, bus.exp_ready}, 64'd3);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.exp_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{64'd13, 64'd13, 1'b0, 1'b0, 16'd1, 16'd0};
        tbl[1] = '{-64'd10, -64'd10, 1'b0, 1'b0, 16'd2, 16'd0};
        tbl[2] = '{-64'd4, -64'd4, 1'b0, 1'b0, 16'd3, 16'd0};
        tbl[3] = '{64'd5, 64'd4, 1'b0, 1'b0, 16'd4, 16'd1};
        tbl[4] = '{64'd0, 64'd10, 1'b1, 1'b0, 16'd5, 16'd2};
        tbl[5] = '{{64{1'b1}}, {64{1'b1}}, 1'b1, 1'b1, 16'd6, 16'd2};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, 16'd7, 16'd3};
        tbl[7] = '{64'd7, 64'd7, 1'b1, 1'b1, 16'd8, 16'd3};
        bus.res_valid = 1'b0; bus.exp_valid = 1'b0;
        bus.result = '0; bus.exp_result = '0; bus.zero = 1'b0; bus.exp_zero = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_status", {busy, done, bus.res_ready, bus.exp_ready, first_err_valid}, 0);
        chk("rst_counts", {vec_count, err_count, first_err_idx}, 0);
        @(negedge clk) reset = 1'b1;

        // Clean three-pair run.
        start_run(16'd3);
        chk("run_busy", {busy, done}, 64'b10);
        send_pair(64'd13, 64'd13, 1'b0, 1'b0);
        send_pair(-64'd10, -64'd10, 1'b0, 1'b0);
        send_pair(-64'd4, -64'd4, 1'b0, 1'b0);
        chk("clean_status", {busy, done, first_err_valid}, 64'b010);
        chk("clean_counts", {vec_count, err_count}, {16'd3, 16'd0});

        // Table run: counters after every pair.
        start_run(16'd8);
        for (int i = 0; i < 8; i++) begin
            send_pair(tbl[i].r, tbl[i].e, tbl[i].z, tbl[i].ez);
            chk($sformatf("tbl_vec[%0d]", i), vec_count, tbl[i].v);
            chk($sformatf("tbl_err[%0d]", i), err_count, tbl[i].er);
            chk($sformatf("tbl_done[%0d]", i), done, i == 7);
        end
        chk("tbl_first", {first_err_valid, first_err_idx}, {1'b1, 16'd3});

        // Two mismatches at indices 2 and 3; first index must restart at this run.
        start_run(16'd4);
        chk("restart_clear", {vec_count, err_count, 15'd0, first_err_valid}, 0);
        send_pair(64'd1, 64'd1, 1'b0, 1'b0);
        send_pair(64'd2, 64'd2, 1'b0, 1'b0);
        send_pair(64'd5, 64'd4, 1'b0, 1'b0);
        send_pair(64'd0, 64'd10, 1'b0, 1'b0);
        chk("two_err", {done, err_count, first_err_valid, first_err_idx}, {1'b1, 16'd2, 1'b1, 16'd2});

        // One-sided valid is held off.
        start_run(16'd1);
        @(negedge clk);
        bus.res_valid = 1'b1; bus.result = 64'd9; bus.exp_result = 64'd9;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("hold_ready[%0d]", i), {bus.res_ready, bus.exp_ready, vec_count}, 0);
            @(negedge clk);
        end
        bus.exp_valid = 1'b1;
        #1 chk("hold_release", {bus.res_ready, bus.exp_ready}, 64'b11);
        @(posedge clk);
        #1 bus.res_valid = 1'b0; bus.exp_valid = 1'b0;
        chk("hold_count", {done, vec_count, err_count}, {1'b1, 16'd1, 16'd0});

        // Zero-flag disagreement with equal results.
        start_run(16'd1);
        send_pair(64'd0, 64'd0, 1'b1, 1'b0);
`ifdef ZERO_CHECK_EN
        chk("zero_flag", {done, err_count}, {1'b1, 16'd1});
`else
        chk("zero_flag", {done, err_count}, {1'b1, 16'd0});
`endif

        // start inside RUN is ignored.
        start_run(16'd7);
        for (int i = 0; i < 3; i++) send_pair(64'(i), 64'(i), 1'b0, 1'b0);
        start_run(16'd2);
        chk("ign_start", {busy, vec_count}, {1'b1, 16'd3});
        for (int i = 3; i < 6; i++) send_pair(64'(i), 64'(i), 1'b0, 1'b0);
        chk("ign_six", {busy, done, vec_count}, {2'b10, 16'd6});
        send_pair(64'd6, 64'd6, 1'b0, 1'b0);
        chk("ign_end", {busy, done, vec_count, err_count}, {2'b01, 16'd7, 16'd0});

        // Mid-run reset, then an empty run.
        start_run(16'd5);
        send_pair(64'd1, 64'd2, 1'b0, 1'b0);
        send_pair(64'd3, 64'd3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_rst_status", {busy, done, bus.res_ready, bus.exp_ready, first_err_valid}, 0);
        chk("mid_rst_counts", {vec_count, err_count, first_err_idx}, 0);
        @(negedge clk) reset = 1'b1;
        start_run(16'd0);
        chk("empty_run", {busy, done, vec_count, err_count}, {2'b01, 16'd0, 16'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
